// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path on the Ram1 data bus.
//   UART_DATA_ADDR / UART_STAT_ADDR : memory-mapped UART register addresses
//   tx_state_e                      : transmit FSM state encoding (3-bit)
//   drives_bus()                    : states in which this block owns Ram1Data
package uart_tx_ctrl_pkg;

    localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4,
        ST_WAIT_TBRE = 3'd5,
        ST_WAIT_TSRE = 3'd6
    } tx_state_e;

    function automatic logic drives_bus(input tx_state_e s);
        return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty); dout shows the head entry
//   full,empty : registered status flags, valid the cycle after push/pop
// DEPTH must be a power of 2 and at least 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_d, rd_ptr_d;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr + {{AW{1'b0}}, do_pop};
    end

    // Flags are computed from the next pointers so they are glitch-free flops
    // yet already reflect the push/pop that happens at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            empty  <= (wr_ptr_d == rd_ptr_d);
            full   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: buffers CPU stores to the UART data register and writes them
// to the UART over the shared Ram1 data bus.
//   clk, rst           : clock, asynchronous active-low reset
//   wr_req, wr_data    : CPU store to UART data address (push when not full)
//   fifo_full          : stall request to the memory stage
//   tx_idle            : FIFO empty and FSM idle (UART status bit 0)
//   bus_req, bus_grant : Ram1 data bus arbitration
//   data_out, data_oe  : byte and tri-state enable for Ram1Data[7:0]
//   wrn                : UART write strobe, active-low
//   tbre, tsre         : UART transmit buffer / shift register empty
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WRN_LOW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       tx_idle,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       wrn,
    input  logic       tbre,
    input  logic       tsre
);

    localparam int unsigned     CNT_W    = (WRN_LOW > 1) ? $clog2(WRN_LOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WRN_LOW - 1);

    tx_state_e        state, next_state;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       tx_byte;
    logic [7:0]       fifo_dout;
    logic             fifo_empty;
    logic             fifo_push, fifo_pop;
    logic             tbre_armed, tbre_armed_d;
    logic             bus_req_d, data_oe_d, wrn_d, tx_idle_d;
    logic [7:0]       data_out_d;

    assign fifo_push = wr_req && !fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .din   (wr_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        next_state   = state;
        cnt_d        = cnt;
        fifo_pop     = 1'b0;
        // Set while in WAIT_TBRE so its first cycle acts as tbre blanking.
        tbre_armed_d = (state == ST_WAIT_TBRE);

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grant) next_state = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_d      = CNT_LOAD;
                next_state = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt == '0) next_state = ST_HOLD;
                else           cnt_d = cnt - CNT_W'(1);
            end
            ST_HOLD: begin
                next_state = ST_WAIT_TBRE;
            end
            ST_WAIT_TBRE: begin
                if (tbre_armed && tbre) next_state = ST_WAIT_TSRE;
            end
            ST_WAIT_TSRE: begin
                if (tsre) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state: same cycle timing as a
        // Moore decode, but the strobe and enable come straight from flops.
        bus_req_d  = (next_state == ST_REQ) || drives_bus(next_state);
        data_oe_d  = drives_bus(next_state);
        wrn_d      = (next_state != ST_STROBE);
        data_out_d = data_oe_d ? tx_byte : '0;
        // Pops only happen when leaving IDLE, so staying idle needs just
        // "empty and nothing arriving".
        tx_idle_d  = (next_state == ST_IDLE) && fifo_empty && !fifo_push;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tbre_armed <= 1'b0;
            tx_byte    <= '0;
            bus_req    <= 1'b0;
            data_oe    <= 1'b0;
            wrn        <= 1'b1;
            data_out   <= '0;
            tx_idle    <= 1'b1;
        end else begin
            state      <= next_state;
            cnt        <= cnt_d;
            tbre_armed <= tbre_armed_d;
            if (fifo_pop) tx_byte <= fifo_dout;
            bus_req    <= bus_req_d;
            data_oe    <= data_oe_d;
            wrn        <= wrn_d;
            data_out   <= data_out_d;
            tx_idle    <= tx_idle_d;
        end
    end

endmodule
